// File: rtl/mmio_interconnect.sv
// Slot-decoding MMIO interconnect between the CPU data port and NUM_SLAVES peripherals,
// with a req/ready handshake, slave timeout and decode-error responses. Optional error log: MMIO_ERR_LOG_EN.
module mmio_interconnect #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int SEL_LSB    = 9,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [3:0]                   m_width,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [3:0]                   s_width,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
`ifdef MMIO_ERR_LOG_EN
    ,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [7:0]                   err_count
`endif
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   s_req_q, s_req_d;
    logic                    s_we_q, s_we_d;
    logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
    logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
    logic [3:0]              s_width_q, s_width_d;
    logic [SEL_W-1:0]        slot_q, slot_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    m_ready_q, m_ready_d;
    logic                    m_err_q, m_err_d;
    logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;

    logic [SEL_W-1:0]        sel_s;
    logic                    sel_ok_s;
    logic [NUM_SLAVES-1:0]   req_hot_s;
    logic                    rdy_sel_s;
    logic [DATA_W-1:0]       rd_sel_s;

    // Decode the incoming slot and mux the ready/read data of the latched slot.
    always_comb begin
        sel_s     = m_addr[SEL_LSB +: SEL_W];
        sel_ok_s  = ({{(32-SEL_W){1'b0}}, sel_s} < 32'(NUM_SLAVES));
        req_hot_s = '0;
        rdy_sel_s = 1'b0;
        rd_sel_s  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_hot_s[i] = (sel_s == SEL_W'(i));
            rdy_sel_s    = rdy_sel_s | (s_ready[i] & (slot_q == SEL_W'(i)));
            rd_sel_s     = rd_sel_s | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{slot_q == SEL_W'(i)}});
        end
    end

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_width_d = s_width_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        m_ready_d = 1'b0;
        m_err_d   = 1'b0;
        m_rdata_d = m_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_width_d = m_width;
                    slot_d    = sel_s;
                    cnt_d     = 8'd0;
                    if (sel_ok_s) begin
                        s_req_d = req_hot_s;
                        state_d = ST_WAIT;
                    end else begin
                        // Unmapped slot: answer straight away without touching any slave.
                        m_ready_d = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        state_d   = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (rdy_sel_s) begin
                    s_req_d   = '0;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b0;
                    m_rdata_d = s_we_q ? {DATA_W{1'b0}} : rd_sel_s;
                    state_d   = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    s_req_d   = '0;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = '0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_width_q <= 4'd0;
            slot_q    <= '0;
            cnt_q     <= 8'd0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_width_q <= s_width_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign s_req   = s_req_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_width = s_width_q;

`ifdef MMIO_ERR_LOG_EN
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              log_s;

    // Capture the failing address and a saturating error count as the error response is issued.
    always_comb begin
        log_s       = m_ready_d & m_err_d;
        err_addr_d  = log_s ? s_addr_d : err_addr_q;
        err_count_d = (log_s && (err_count_q != 8'd255)) ? (err_count_q + 8'd1) : err_count_q;
    end

    // Error log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q  <= '0;
            err_count_q <= 8'd0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mmio_interconnect.sv
// Randomized self-checking bench for mmio_interconnect (3 slots, so select code 3 is unmapped).
module tb_mmio_interconnect;

    localparam int NS = 3;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m_req, m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [3:0]        m_width;
    logic [DW-1:0]     m_rdata;
    logic              m_ready, m_err;
    logic [NS-1:0]     s_req;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [3:0]        s_width;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;
`ifdef MMIO_ERR_LOG_EN
    logic [AW-1:0]     err_addr;
    logic [7:0]        err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Error-log reference: last errored address and saturating count.
    int            log_cnt = 0;
    logic [AW-1:0] log_addr = '0;

    always #5 clk = ~clk;

    mmio_interconnect #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(9), .TIMEOUT(TO)
    ) dut (
`ifdef MMIO_ERR_LOG_EN
        .err_addr(err_addr),
        .err_count(err_count),
`endif
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One master transaction; lat = WAIT cycles before the slave readies (>= TO means never).
    task automatic run_txn(input logic we, input logic [1:0] code, input logic [8:0] off,
                           input logic [31:0] wd, input logic [3:0] wid, input int lat,
                           input bit use_fixed, input logic [31:0] fixed_rd);
        logic [AW-1:0] addr;
        logic [NS-1:0] onehot;
        logic [NS-1:0] noise;
        logic [31:0]   rd_exp;
        logic [31:0]   exp_rd;
        bit            dec_err;
        bit            exp_err;
        int            exp_k;
        int            got_k;
        addr    = {code, off};
        dec_err = (int'(code) >= NS);
        onehot  = '0;
        if (!dec_err) onehot[code] = 1'b1;
        rd_exp  = '0;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_width = wid;
        @(posedge clk);
        @(negedge clk);
        // Master bus is scrambled while the transaction is in flight; the DUT must ignore it.
        m_req = 1'b0; m_we = 1'($urandom); m_addr = AW'($urandom);
        m_wdata = $urandom; m_width = 4'($urandom);
        got_k = 0;
        for (int k = 1; k <= TO + 4; k++) begin
            if (k > 1) @(negedge clk);
            if (m_ready) begin
                got_k = k;
                break;
            end
            check_eq("s_req", 64'(s_req), 64'(onehot));
            check_eq("s_bus", {16'd0, s_we, s_width, s_addr, s_wdata}, {16'd0, we, wid, addr, wd});
            for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
            if (use_fixed && !dec_err) s_rdata[code*DW +: DW] = fixed_rd;
            noise = NS'($urandom) & ~onehot;
            if (k - 1 == lat) begin
                s_ready = noise | onehot;
                if (!dec_err) rd_exp = s_rdata[code*DW +: DW];
            end else begin
                s_ready = noise;
            end
        end
        s_ready = '0;
        if (dec_err) begin
            exp_k = 1; exp_err = 1'b1; exp_rd = '0;
        end else if (lat < TO) begin
            exp_k = lat + 2; exp_err = 1'b0; exp_rd = we ? 32'd0 : rd_exp;
        end else begin
            exp_k = TO + 1; exp_err = 1'b1; exp_rd = '0;
        end
        if (exp_err) begin
            log_cnt  = (log_cnt < 255) ? log_cnt + 1 : 255;
            log_addr = addr;
        end
        check_eq("latency", 64'(got_k), 64'(exp_k));
        check_eq("m_err", 64'(m_err), 64'(exp_err));
        check_eq("m_rdata", 64'(m_rdata), 64'(exp_rd));
`ifdef MMIO_ERR_LOG_EN
        check_eq("err_addr", 64'(err_addr), 64'(log_addr));
        check_eq("err_count", 64'(err_count), 64'(log_cnt));
`endif
        @(negedge clk);
        check_eq("ready_pulse", 64'(m_ready), 64'd0);
        check_eq("rdata_hold", 64'(m_rdata), 64'(exp_rd));
    endtask

    initial begin
        int r;
        int lat;
        rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_width = 4'd0;
        s_rdata = '0; s_ready = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", {31'd0, m_ready, m_err, m_rdata}, 64'd0);
        check_eq("rst_sbus", {16'd0, s_we, s_width, s_addr, s_wdata}, 64'd0);
        check_eq("rst_sreq", 64'(s_req), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 2'd1, 9'h055, 32'd0, 4'hF, 0, 1'b1, 32'hDEADBEEF);
        run_txn(1'b1, 2'd2, 9'h004, 32'h000000A5, 4'b0001, 4, 1'b0, 32'd0);
        run_txn(1'b0, 2'd3, 9'h012, 32'd0, 4'hF, 0, 1'b0, 32'd0);
        run_txn(1'b0, 2'd0, 9'h100, 32'd0, 4'hF, 255, 1'b0, 32'd0);
        run_txn(1'b0, 2'd0, 9'h101, 32'd0, 4'hF, TO - 1, 1'b0, 32'd0);
        run_txn(1'b0, 2'd1, 9'h102, 32'd0, 4'hF, TO, 1'b0, 32'd0);

        // Asynchronous reset in the middle of a WAIT: request drops at once, no response follows.
        m_req = 1'b1; m_we = 1'b0; m_addr = 11'h210; m_wdata = '0; m_width = 4'hF;
        @(posedge clk);
        @(negedge clk);
        m_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_sreq", 64'(s_req), 64'd0);
        check_eq("rst_async_ready", 64'(m_ready), 64'd0);
        log_cnt = 0;
        log_addr = '0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_ready", 64'(m_ready), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(m_ready), 64'd0);
        run_txn(1'b0, 2'd1, 9'h033, 32'd0, 4'hF, 1, 1'b0, 32'd0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       lat = $urandom_range(0, 5);
            else if (r == 6) lat = TO - 1;
            else if (r == 7) lat = TO;
            else if (r == 8) lat = 255;
            else             lat = $urandom_range(6, 13);
            run_txn(1'($urandom), 2'($urandom), 9'($urandom), $urandom, 4'($urandom), lat,
                    1'b0, 32'd0);
        end

`ifdef MMIO_ERR_LOG_EN
        for (int n = 0; n < 300; n++) begin
            run_txn(1'($urandom), 2'($urandom_range(0, 2)), 9'($urandom), $urandom, 4'hF, 255,
                    1'b0, 32'd0);
        end
        check_eq("err_count_sat", 64'(err_count), 64'd255);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
